// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester ALU sharing arbiter.
// Holds the ALU opcode map, the legality bound, and the stage payload
// structs used by the ISSUE and RESP registers.
package alu_share_pkg;

  localparam int unsigned NREQ = 2;
  localparam int unsigned W    = 32;

  // ALU control codes
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0110;
  localparam logic [3:0] OP_GT  = 4'b0111;
  localparam logic [3:0] OP_LT  = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1001;

  // Highest opcode the ALU understands; everything above is reported as err.
  localparam logic [3:0] OP_MAX_LEGAL = 4'b1001;

  // Operation held in the ISSUE stage. op is the code actually sent to the ALU
  // (already forced to ADD for illegal requests).
  typedef struct packed {
    logic         id;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   shamt;
    logic         err;
  } issue_t;

  // Response held in the RESP stage.
  typedef struct packed {
    logic         id;
    logic [W-1:0] result;
    logic         ovf;
    logic         zero;
    logic         err;
  } resp_t;

  function automatic logic is_legal_op(logic [3:0] op);
    return op <= OP_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Bundle of the request, ALU-control and response channels of the ALU
// sharing arbiter.
//   slave  : view of the arbiter (takes requests, drives ALU and responses)
//   master : view of the surroundings (requesters, ALU instance, consumer)
// Request channel : req_valid/req_ready per requester, req_op/a/b/shamt data
// ALU channel     : alu_in1/in2/ctrl/shamt out, alu_out/ovf/zero back
// Response channel: resp_valid/resp_ready, resp_id/result/ovf/zero/err
interface alu_share_arb_if #(
  parameter int unsigned W = 32
);

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0][3:0]    req_op;
  logic [1:0][W-1:0]  req_a;
  logic [1:0][W-1:0]  req_b;
  logic [1:0][4:0]    req_shamt;

  logic [W-1:0]       alu_in1;
  logic [W-1:0]       alu_in2;
  logic [3:0]         alu_ctrl;
  logic [4:0]         alu_shamt;
  logic [W-1:0]       alu_out;
  logic               alu_ovf;
  logic               alu_zero;

  logic               resp_valid;
  logic               resp_ready;
  logic               resp_id;
  logic [W-1:0]       resp_result;
  logic               resp_ovf;
  logic               resp_zero;
  logic               resp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_shamt,
    input  alu_out, alu_ovf, alu_zero,
    input  resp_ready,
    output req_ready,
    output alu_in1, alu_in2, alu_ctrl, alu_shamt,
    output resp_valid, resp_id, resp_result, resp_ovf, resp_zero, resp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_shamt,
    output alu_out, alu_ovf, alu_zero,
    output resp_ready,
    input  req_ready,
    input  alu_in1, alu_in2, alu_ctrl, alu_shamt,
    input  resp_valid, resp_id, resp_result, resp_ovf, resp_zero, resp_err
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker (purely combinational).
//   valid     : request valid per requester
//   prio      : requester that wins when both are valid
//   en        : grant allowed this cycle
//   grant_vld : a requester is granted
//   grant_id  : index of the granted requester (0 when nothing is granted)
// The priority pointer is owned by the caller.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       prio,
  input  logic       en,
  output logic       grant_vld,
  output logic       grant_id
);

  always_comb begin
    grant_vld = en & (|valid);
    grant_id  = 1'b0;
    if (en) begin
      // Contention goes to prio; otherwise the lone valid requester wins.
      grant_id = (&valid) ? prio : valid[1];
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one ALU between the EX slot
// (requester 0) and the branch/address helper (requester 1).
//   clk   : rising-edge clock
//   reset : synchronous, active-high; drops everything in flight
//   bus   : request, ALU-control and response channels (slave view)
// Two register stages: ISSUE drives the ALU operands, RESP captures the
// ALU result and presents it tagged with the requester id. One op per cycle
// when the consumer keeps resp_ready high; latency accept -> resp is 2 edges.
module alu_share_arb
  import alu_share_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  alu_share_arb_if.slave bus
);

  issue_t issue_q, issue_d;
  logic   issue_valid_q, issue_valid_d;
  resp_t  resp_q, resp_d;
  logic   resp_valid_q, resp_valid_d;
  logic   prio_q, prio_d;

  logic   advance_resp;
  logic   advance_issue;
  logic   grant_vld;
  logic   grant_id;
  logic   req_legal;
  issue_t new_entry;

  // Stage advance conditions
  always_comb begin
    advance_resp  = ~resp_valid_q | bus.resp_ready;
    advance_issue = ~issue_valid_q | advance_resp;
  end

  // Reset keeps ready low so nothing is accepted during reset.
  rr_pick2 u_pick (
    .valid     (bus.req_valid),
    .prio      (prio_q),
    .en        (advance_issue & ~reset),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = grant_vld & (grant_id == 1'(i));
    end
  end

  // Entry built from the granted requester
  always_comb begin
    req_legal          = is_legal_op(bus.req_op[grant_id]);
    new_entry.id       = grant_id;
    new_entry.op       = req_legal ? bus.req_op[grant_id] : OP_ADD;
    new_entry.a        = bus.req_a[grant_id];
    new_entry.b        = bus.req_b[grant_id];
    new_entry.shamt    = bus.req_shamt[grant_id];
    new_entry.err      = ~req_legal;
  end

  // ISSUE stage and priority pointer
  always_comb begin
    issue_d       = issue_q;
    issue_valid_d = issue_valid_q;
    prio_d        = prio_q;
    if (advance_issue) begin
      issue_valid_d = grant_vld;
    end
    // Operands only change on accept so the ALU does not toggle while idle.
    if (grant_vld) begin
      issue_d = new_entry;
      prio_d  = ~grant_id;
    end
  end

  // RESP stage
  always_comb begin
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
    if (advance_resp) begin
      resp_valid_d = issue_valid_q;
      if (issue_valid_q) begin
        resp_d.id     = issue_q.id;
        resp_d.err    = issue_q.err;
        // Illegal ops report a clean zero result regardless of the ALU.
        resp_d.result = issue_q.err ? '0   : bus.alu_out;
        resp_d.ovf    = issue_q.err ? 1'b0 : bus.alu_ovf;
        resp_d.zero   = issue_q.err ? 1'b0 : bus.alu_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_q       <= '0;
      issue_valid_q <= 1'b0;
      resp_q        <= '0;
      resp_valid_q  <= 1'b0;
      prio_q        <= 1'b0;
    end else begin
      issue_q       <= issue_d;
      issue_valid_q <= issue_valid_d;
      resp_q        <= resp_d;
      resp_valid_q  <= resp_valid_d;
      prio_q        <= prio_d;
    end
  end

  // Outputs
  always_comb begin
    bus.alu_in1     = issue_q.a;
    bus.alu_in2     = issue_q.b;
    bus.alu_ctrl    = issue_q.op;
    bus.alu_shamt   = issue_q.shamt;
    bus.resp_valid  = resp_valid_q;
    bus.resp_id     = resp_q.id;
    bus.resp_result = resp_q.result;
    bus.resp_ovf    = resp_q.ovf;
    bus.resp_zero   = resp_q.zero;
    bus.resp_err    = resp_q.err;
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: behavioural ALU, queue-based reference model of
// the two-deep pipeline, directed scenarios followed by random traffic.
module tb_alu_share_arb;
  import alu_share_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_share_arb_if #(.W(32)) bus ();

  alu_share_arb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural ALU: {ovf, zero, result}
  function automatic logic [33:0] alu_f(logic [3:0] c, logic [31:0] a, logic [31:0] b,
                                        logic [4:0] sh);
    logic [31:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (c)
      OP_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_SLL: r = a << sh;
      OP_SRL: r = a >> sh;
      OP_SRA: r = $unsigned($signed(a) >>> sh);
      OP_GT:  r = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      OP_LT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_NOR: r = ~(a | b);
      default: r = '0;
    endcase
    return {v, (r == 32'd0), r};
  endfunction

  always_comb begin
    {bus.alu_ovf, bus.alu_zero, bus.alu_out} =
      alu_f(bus.alu_ctrl, bus.alu_in1, bus.alu_in2, bus.alu_shamt);
  end

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
  } op_t;

  // Expected response: {err, ovf, zero, result}
  function automatic logic [34:0] exp_resp(op_t e);
    logic [33:0] r;
    if (e.op > 4'd9) return {1'b1, 34'd0};
    r = alu_f(e.op, e.a, e.b, e.sh);
    return {1'b0, r};
  endfunction

  // Reference model: ops in order; head is on the response port when shown=1.
  op_t  pipe[$];
  bit   shown;
  logic mprio;
  logic [1:0] acc;
  logic [1:0] obs_ready;

  int checks;
  int errors;
  int n_resp;
  logic        last_id;
  logic [31:0] last_result;
  logic        last_ovf, last_zero, last_err;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [1:0]  er;
    logic        w;
    op_t         nw;
    op_t         e;
    logic [34:0] x;
    int          idx;
    er = 2'b00;
    w  = 1'b0;
    @(negedge clk);
    if (!reset && bus.req_valid != 2'b00 && (pipe.size() < 2 || bus.resp_ready)) begin
      w = (bus.req_valid == 2'b11) ? mprio : bus.req_valid[1];
      er[w] = 1'b1;
    end
    obs_ready = bus.req_ready;
    chk("req_ready", bus.req_ready, er);
    chk("resp_valid", bus.resp_valid, shown);
    if (shown) begin
      e = pipe[0];
      x = exp_resp(e);
      chk("resp_id", bus.resp_id, e.id);
      chk("resp_result", bus.resp_result, x[31:0]);
      chk("resp_flags", {bus.resp_err, bus.resp_ovf, bus.resp_zero}, x[34:32]);
    end
    idx = shown ? 1 : 0;
    if (pipe.size() > idx) begin
      e = pipe[idx];
      chk("alu_in1", bus.alu_in1, e.a);
      chk("alu_in2", bus.alu_in2, e.b);
      chk("alu_ctrl", bus.alu_ctrl, (e.op > 4'd9) ? 4'd0 : e.op);
      chk("alu_shamt", bus.alu_shamt, e.sh);
    end
    if (!reset && bus.resp_valid && bus.resp_ready) begin
      n_resp++;
      last_id = bus.resp_id;
      last_result = bus.resp_result;
      last_ovf = bus.resp_ovf;
      last_zero = bus.resp_zero;
      last_err = bus.resp_err;
    end
    nw.id = w;
    nw.op = bus.req_op[w];
    nw.a  = bus.req_a[w];
    nw.b  = bus.req_b[w];
    nw.sh = bus.req_shamt[w];
    @(posedge clk);
    if (reset) begin
      pipe.delete();
      shown = 0;
      mprio = 1'b0;
      acc   = 2'b00;
    end else begin
      if (shown && bus.resp_ready) begin
        void'(pipe.pop_front());
        shown = (pipe.size() > 0);
      end else if (!shown) begin
        shown = (pipe.size() > 0);
      end
      if (er != 2'b00) begin
        pipe.push_back(nw);
        mprio = ~w;
      end
      acc = er;
    end
    #1;
  endtask

  task automatic drv(int i, logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    bus.req_valid[i] = 1'b1;
    bus.req_op[i]    = op;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
    bus.req_shamt[i] = sh;
  endtask

  task automatic idle(int i);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp();
    int start;
    int k;
    start = n_resp;
    k = 0;
    while (n_resp == start && k < 10) begin
      tick();
      k++;
    end
    chk("resp_arrived", (n_resp != start), 1);
  endtask

  task automatic exp_last(string tag, logic id, logic [31:0] res, logic ovf, logic zero,
                          logic err);
    chk({tag, "_id"}, last_id, id);
    chk({tag, "_result"}, last_result, res);
    chk({tag, "_flags"}, {last_err, last_ovf, last_zero}, {err, ovf, zero});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int g0, g1, k, t, start;
    checks = 0; errors = 0; n_resp = 0;
    shown = 0; mprio = 1'b0; acc = 2'b00;
    bus.req_valid = 2'b00; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_shamt = '0; bus.resp_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Requests during reset are never accepted
    drv(0, OP_ADD, 32'd1, 32'd1, 5'd0);
    drv(1, OP_ADD, 32'd2, 32'd2, 5'd0);
    tick();
    idle(0); idle(1);
    reset = 1'b0;
    chk("rst_alu_in1", bus.alu_in1, 0);
    chk("rst_alu_in2", bus.alu_in2, 0);
    chk("rst_alu_ctrl_shamt", {bus.alu_ctrl, bus.alu_shamt}, 0);
    chk("rst_resp", {bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_ovf,
                     bus.resp_zero, bus.resp_err}, 0);
    tick();

    // Single requester ADD 5+7
    drv(0, OP_ADD, 32'd5, 32'd7, 5'd0);
    tick();
    idle(0);
    chk("add_ctrl", bus.alu_ctrl, OP_ADD);
    wait_resp();
    exp_last("add", 1'b0, 32'd12, 1'b0, 1'b0, 1'b0);

    // Contention: grants alternate
    drv(0, OP_SUB, 32'd10, 32'd3, 5'd0);
    drv(1, OP_OR, 32'h0000_00F0, 32'h0000_000F, 5'd0);
    g0 = 0; g1 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      g0 += int'(obs_ready[0]);
      g1 += int'(obs_ready[1]);
    end
    chk("cont_grants0", g0, 4);
    chk("cont_grants1", g1, 4);
    idle(0); idle(1);
    repeat (3) tick();

    // Backpressure: 4 ops from req1, consumer stalls for 4 cycles
    k = 0; t = 0; start = n_resp;
    while ((k < 4 || pipe.size() > 0) && t < 40) begin
      bus.resp_ready = !(t >= 2 && t < 6);
      if (k < 4) drv(1, OP_ADD, k, 32'd100, 5'd0);
      else idle(1);
      tick();
      if (acc[1]) k++;
      t++;
    end
    idle(1);
    bus.resp_ready = 1'b1;
    chk("bp_count", n_resp - start, 4);
    exp_last("bp_last", 1'b1, 32'd103, 1'b0, 1'b0, 1'b0);

    // Illegal opcode
    drv(0, 4'b1100, 32'd1, 32'd1, 5'd0);
    tick();
    idle(0);
    chk("ill_ctrl", bus.alu_ctrl, 4'b0000);
    wait_resp();
    exp_last("ill", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    // Flags
    drv(1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
    tick();
    idle(1);
    wait_resp();
    exp_last("ovf", 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    drv(0, OP_SUB, 32'd9, 32'd9, 5'd0);
    tick();
    idle(0);
    wait_resp();
    exp_last("zero", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Reset with both stages occupied
    drv(0, OP_ADD, 32'd1, 32'd2, 5'd0);
    tick();
    drv(0, OP_ADD, 32'd3, 32'd4, 5'd0);
    tick();
    idle(0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_resp_valid", bus.resp_valid, 0);
    start = n_resp;
    repeat (4) tick();
    chk("mid_rst_no_stale", n_resp - start, 0);
    drv(0, OP_SUB, 32'd10, 32'd3, 5'd0);
    drv(1, OP_OR, 32'h0000_00F0, 32'h0000_000F, 5'd0);
    tick();
    chk("mid_rst_prio", obs_ready, 2'b01);
    idle(0); idle(1);
    repeat (3) tick();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      bus.resp_ready = ($urandom_range(3) != 0);
      reset = ($urandom_range(127) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!bus.req_valid[i] || acc[i]) begin
          if ($urandom_range(2) != 0) begin
            drv(i, 4'($urandom_range(15)),
                ($urandom_range(3) == 0) ? 32'h7FFF_FFFF : $urandom,
                ($urandom_range(3) == 0) ? 32'($urandom_range(3)) : $urandom,
                5'($urandom_range(31)));
          end else begin
            idle(i);
          end
        end
      end
      tick();
    end
    reset = 1'b0;
    idle(0); idle(1);
    bus.resp_ready = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
